// File: rtl/addsub_pkg.sv
// Shared constants and the result record for the addsub initiator.
package addsub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // One returned result: datapath sum/difference plus the op tag it came from.
  typedef struct packed {
    logic [WIDTH_DEFAULT:0] result;
    logic                   add;
  } res_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; any depth >= 1, pointers wrap modulo Depth.
module sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  output logic [Width-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so push at full is fine then.
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Head is forced to zero when empty so idle outputs read as reset values.
  assign rdata   = empty ? '0 : mem[rptr_q];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Upstream credit accounting must never let data arrive at a full queue.
  push_while_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: rtl/addsub_master.sv
// Initiator for a 1-cycle registered add/sub datapath: issue, in-flight tracking,
// credit-limited result queue returned in command order.
module addsub_master
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_add,
  output logic [WIDTH-1:0] dataa,
  output logic [WIDTH-1:0] datab,
  output logic             add_sub,
  input  logic [WIDTH:0]   res_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic             out_add
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RecW = WIDTH + 2;

  logic            issue_v_q;
  logic            inflight_v_q;
  logic            inflight_add_q;
  logic            accept;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   used;
  logic [RecW-1:0] head;

  // Credits cover queued results plus both pipeline stages, all from registered state.
  always_comb begin
    used      = (CntW+1)'(fifo_count) + (CntW+1)'(issue_v_q) + (CntW+1)'(inflight_v_q);
    cmd_ready = rst_n && (used < (CntW+1)'(DEPTH));
    accept    = cmd_valid && cmd_ready;
  end

  // Issue register feeds the datapath; in-flight stage tracks the op it is computing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataa          <= '0;
      datab          <= '0;
      add_sub        <= OP_SUB;
      issue_v_q      <= 1'b0;
      inflight_v_q   <= 1'b0;
      inflight_add_q <= OP_SUB;
    end else begin
      issue_v_q      <= accept;
      inflight_v_q   <= issue_v_q;
      // add_sub still holds the issued op's tag here even if a new accept lands now.
      inflight_add_q <= add_sub;
      if (accept) begin
        dataa   <= cmd_a;
        datab   <= cmd_b;
        add_sub <= cmd_add;
      end
    end
  end

  sync_fifo #(
    .Width (RecW),
    .Depth (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_v_q),
    .wdata ({res_in, inflight_add_q}),
    .pop   (out_valid && out_ready),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid             = !fifo_empty;
  assign {out_result, out_add} = head;

endmodule
